layer_out_serializer: RTL and testbench
=======================================

LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 Parameter numNeuron, default 48: number of neurons in the producing layer; must be at least 2.
REQ-002 Parameter inWidth, default `ROM_bitwidth: activation output width per neuron; must not exceed `dataWidth.
REQ-003 Parameter idxWidth, default $clog2(numNeuron): width of the stream index.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 neuron_out  input  numNeuron*inWidth  concatenated neuron activations; neuron k occupies bits [k*inWidth +: inWidth].
REQ-007 neuron_valid  input  numNeuron  per-neuron outvalid pulses; bit k qualifies slice k.
REQ-008 out_ready  input  1  downstream layer accepts a word this cycle.
REQ-009 out_data  output  `dataWidth  serialized activation; feeds the next layer's myinput.
REQ-010 out_valid  output  1  out_data is valid; feeds the next layer's myinputValid.
REQ-011 out_idx  output  idxWidth  neuron index of the current out_data.
REQ-012 layer_done  output  1  single-cycle pulse after the last word is transferred.
REQ-013 overrun  output  1  sticky error flag, cleared only by rst.

Function
REQ-014 The FSM SHALL have two states: COLLECT and STREAM.
REQ-015 In COLLECT, each cycle, for every k with neuron_valid[k]=1 and captured[k]=0: buf[k] <= neuron_out slice k and captured[k] <= 1.
REQ-016 Multiple neuron_valid bits asserted in one cycle SHALL all be captured in that cycle.
REQ-017 In COLLECT, neuron_valid[k]=1 with captured[k]=1 SHALL leave buf[k] unchanged and set overrun.
REQ-018 The FSM SHALL move to STREAM on the edge where the capture mask becomes all ones, counting captures made on that same edge; rd_idx <= 0.
REQ-019 Latency: out_valid SHALL rise exactly 1 cycle after the cycle in which the final outstanding neuron_valid is sampled.
REQ-020 In STREAM: out_valid=1, out_data = zero-extended buf[rd_idx] to `dataWidth, out_idx = rd_idx.
REQ-021 A transfer occurs when out_valid & out_ready; rd_idx SHALL then increment by 1.
REQ-022 out_data and out_idx SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 When the transfer at rd_idx = numNeuron-1 occurs, the block SHALL, on that edge: return to COLLECT, clear captured and rd_idx, and assert layer_done for the following cycle only.
REQ-024 Any neuron_valid bit asserted in STREAM SHALL be ignored for capture and SHALL set overrun.
REQ-025 neuron_valid asserted in the layer_done cycle SHALL be captured normally, because the FSM is already in COLLECT.
REQ-026 out_valid SHALL be 0 in COLLECT; out_data is don't-care whenever out_valid=0.

Reset
REQ-027 rst SHALL force: state=COLLECT, captured=0, rd_idx=0, out_valid=0, out_idx=0, layer_done=0, overrun=0.
REQ-028 rst asserted mid-COLLECT or mid-STREAM SHALL abort the layer with no layer_done pulse; partial captures are discarded.
REQ-029 The contents of buf SHALL NOT be reset.
REQ-030 rst SHALL take priority over neuron_valid and out_ready in the same cycle.

Structure
REQ-031 `dataWidth and `ROM_bitwidth SHALL come from the shared include header; no new global defines are added.
REQ-032 The FSM state encodings SHALL be localparams inside the module.
REQ-033 The block SHALL be a single module with no sub-modules; buf is an inferred register array.

Verification
REQ-034 Fill and drain: numNeuron=4, neurons 0..3 valid in separate cycles with values 8'h11, 8'h22, 8'h33, 8'h44, out_ready=1 -> out_valid rises 1 cycle after the last valid; words 11, 22, 33, 44 on consecutive cycles with out_idx 0..3; layer_done pulses once.
REQ-035 Simultaneous arrival: all 4 neuron_valid bits high in one cycle -> all captured, out_valid high on the next cycle.
REQ-036 Backpressure: out_ready toggles 1,0,0,1,... -> out_data and out_idx hold during stalls; exactly 4 transfers; no word lost or duplicated.
REQ-037 Overrun: neuron 2 valid twice during COLLECT (first 8'hAA, then 8'hBB) -> buf[2] stays AA and overrun=1; a further valid during STREAM leaves overrun=1 and the stream unchanged.
REQ-038 Reset mid-stream: rst asserted after 2 transfers -> out_valid=0 next cycle, no layer_done pulse; a new full layer then streams correctly from idx 0.
REQ-039 Back-to-back layers: a valid arrives in the layer_done cycle -> it is captured; the second layer streams its values with no stale data from the first layer.

Source files
------------

// File: rtl/layer_out_serializer_pkg.sv
// Shared widths for the layer output serializer.
// The guarded defaults stand in for the shared include header when it is absent.
`ifndef dataWidth
`define dataWidth 16
`endif
`ifndef ROM_bitwidth
`define ROM_bitwidth 8
`endif

package layer_out_serializer_pkg;

  localparam int unsigned DataWidth = `dataWidth;
  localparam int unsigned RomWidth  = `ROM_bitwidth;

endpackage

// File: rtl/layer_out_serializer.sv
// Collects one activation per neuron of a layer, then streams them in index order
// to the next layer with valid/ready handshaking.
module layer_out_serializer
  import layer_out_serializer_pkg::*;
#(
  parameter int unsigned numNeuron = 48,
  parameter int unsigned inWidth   = RomWidth,
  parameter int unsigned idxWidth  = $clog2(numNeuron)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*inWidth-1:0]   neuron_out,
  input  logic [numNeuron-1:0]           neuron_valid,
  input  logic                           out_ready,
  output logic [DataWidth-1:0]           out_data,
  output logic                           out_valid,
  output logic [idxWidth-1:0]            out_idx,
  output logic                           layer_done,
  output logic                           overrun
);

  localparam logic StCollect = 1'b0;
  localparam logic StStream  = 1'b1;
  localparam logic [idxWidth-1:0] LastIdx = idxWidth'(numNeuron - 1);

  logic                 state_q, state_d;
  logic [numNeuron-1:0] captured_q, captured_d, cap_en;
  logic [idxWidth-1:0]  rd_idx_q, rd_idx_d;
  logic                 layer_done_q, layer_done_d;
  logic                 overrun_q, overrun_d;
  logic [inWidth-1:0]   buf_q [numNeuron];

  always_comb begin
    state_d      = state_q;
    captured_d   = captured_q;
    rd_idx_d     = rd_idx_q;
    layer_done_d = 1'b0;
    overrun_d    = overrun_q;
    cap_en       = '0;
    case (state_q)
      StCollect: begin
        cap_en     = neuron_valid & ~captured_q;
        captured_d = captured_q | cap_en;
        if (|(neuron_valid & captured_q)) overrun_d = 1'b1;
        // Captures landing on this edge count toward completing the layer.
        if (&captured_d) begin
          state_d  = StStream;
          rd_idx_d = '0;
        end
      end
      default: begin
        if (|neuron_valid) overrun_d = 1'b1;
        if (out_ready) begin
          if (rd_idx_q == LastIdx) begin
            state_d      = StCollect;
            captured_d   = '0;
            rd_idx_d     = '0;
            layer_done_d = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + idxWidth'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StCollect;
      captured_q   <= '0;
      rd_idx_q     <= '0;
      layer_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      captured_q   <= captured_d;
      rd_idx_q     <= rd_idx_d;
      layer_done_q <= layer_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Activation storage carries no reset; the capture mask alone marks it live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(numNeuron); k++) begin
      if (cap_en[k] && !rst) buf_q[k] <= neuron_out[k*inWidth +: inWidth];
    end
  end

  assign out_valid  = (state_q == StStream);
  assign out_idx    = rd_idx_q;
  assign out_data   = DataWidth'(buf_q[rd_idx_q]);
  assign layer_done = layer_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with four 8-bit neurons and 16-bit output words.
module tb_layer_out_serializer;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] neuron_out;
  logic [N-1:0]  neuron_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic          out_valid;
  logic [1:0]    out_idx;
  logic          layer_done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  layer_out_serializer #(
    .numNeuron(N),
    .inWidth  (W),
    .idxWidth (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .neuron_out  (neuron_out),
    .neuron_valid(neuron_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .layer_done  (layer_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; neuron_valid = '0; out_ready = 1'b0; neuron_out = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_all(input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3);
    neuron_out   = {v3, v2, v1, v0};
    neuron_valid = 4'b1111;
    tick();
    neuron_valid = '0;
  endtask

  // Drains with out_ready held high, checking each word and the done pulse.
  task automatic drain_expect(input string name, input logic [7:0] v0, input logic [7:0] v1,
                              input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0] exp [4];
    exp[0] = v0; exp[1] = v1; exp[2] = v2; exp[3] = v3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== {8'h00, exp[i]} || out_idx !== 2'(i)) begin
        errors++;
        $display("FAIL %s word%0d: got v=%b d=%h i=%0d, expected v=1 d=%h i=%0d",
                 name, i, out_valid, out_data, out_idx, {8'h00, exp[i]}, i);
      end
      checks++;
      if (layer_done !== 1'b0) begin
        errors++;
        $display("FAIL %s early_done%0d: got %b expected 0", name, i, layer_done);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (layer_done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%b v=%b expected done=1 v=0",
               name, layer_done, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; neuron_valid = 4'b1111; out_ready = 1'b1; neuron_out = 32'hDEADBEEF;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 2'd0 || layer_done !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b i=%0d done=%b ovr=%b expected all 0",
               out_valid, out_idx, layer_done, overrun);
    end
    rst = 1'b0;
    neuron_valid = 4'b0111;
    tick();
    neuron_valid = '0;
    tick();
    // Captures during reset must not count, so three neurons do not complete the layer.
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got v=%b ovr=%b expected v=0 ovr=0", out_valid, overrun);
    end
    do_reset();
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      neuron_out = '0;
      neuron_out[k*W +: W] = vals[k];
      neuron_valid = 4'(1 << k);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL fill_collect%0d: got v=%b expected 0", k, out_valid);
      end
      tick();
    end
    neuron_valid = '0;
    drain_expect("fill_drain", 8'h11, 8'h22, 8'h33, 8'h44);
    tick();
    checks++;
    if (layer_done !== 1'b0) begin
      errors++;
      $display("FAIL fill_done_single: got %b expected 0", layer_done);
    end
  endtask

  task automatic test_simultaneous();
    load_all(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL simult_latency: got v=%b expected 1", out_valid);
    end
    drain_expect("simult", 8'h5A, 8'h6B, 8'h7C, 8'h8D);
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4];
    logic [2:0] pat;
    int nxt = 0;
    int dones = 0;
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3; exp[3] = 8'hA4;
    pat = 3'b001;
    load_all(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    for (int c = 0; c < 16; c++) begin
      out_ready = pat[c % 3];
      if (out_valid === 1'b1) begin
        checks++;
        if (nxt >= 4 || out_data !== {8'h00, exp[nxt]} || out_idx !== 2'(nxt)) begin
          errors++;
          $display("FAIL bp_word c%0d: got d=%h i=%0d expected word %0d", c, out_data,
                   out_idx, nxt);
        end
      end
      if (layer_done === 1'b1) dones++;
      if (out_valid === 1'b1 && out_ready === 1'b1) nxt++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (nxt !== 4 || dones !== 1) begin
      errors++;
      $display("FAIL bp_count: got xfers=%0d dones=%0d expected 4 and 1", nxt, dones);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    neuron_out = 32'h00AA0000; neuron_valid = 4'b0100;
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: got %b expected 0", overrun);
    end
    neuron_out = 32'h00BB0000;
    tick();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_dup: got %b expected 1", overrun);
    end
    neuron_out = 32'h44CC1122; neuron_valid = 4'b1011;
    tick();
    neuron_out = 32'h000000FF; neuron_valid = 4'b0001;
    tick();
    neuron_valid = '0;
    checks++;
    if (overrun !== 1'b1 || out_data !== 16'h0022 || out_idx !== 2'd0) begin
      errors++;
      $display("FAIL ovr_stream: got ovr=%b d=%h i=%0d expected 1 0022 0",
               overrun, out_data, out_idx);
    end
    drain_expect("ovr_drain", 8'h22, 8'h11, 8'hAA, 8'h44);
    tick();
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    load_all(8'h01, 8'h02, 8'h03, 8'h04);
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || layer_done !== 1'b0 || out_idx !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid: got v=%b done=%b i=%0d expected 0 0 0",
               out_valid, layer_done, out_idx);
    end
    tick();
    checks++;
    if (layer_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_nodone: got %b expected 0", layer_done);
    end
    load_all(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    drain_expect("rst_restart", 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    tick();
  endtask

  task automatic test_back_to_back();
    load_all(8'hE1, 8'hE2, 8'hE3, 8'hE4);
    drain_expect("b2b_first", 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    // Still in the done cycle: this capture must count toward the next layer.
    neuron_out = 32'h00000071; neuron_valid = 4'b0001;
    tick();
    neuron_out = 32'h74737200; neuron_valid = 4'b1110;
    tick();
    neuron_valid = '0;
    drain_expect("b2b_second", 8'h71, 8'h72, 8'h73, 8'h74);
    tick();
  endtask

  initial begin
    rst = 1'b1; neuron_valid = '0; out_ready = 1'b0; neuron_out = '0;
    #1;
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_backpressure();
    test_overrun();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
